// File: rtl/ctrl_pkg.sv
// Shared control encodings for the stage sequencer: FSM states, next-PC sources
// and opcode constants.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_REL = 2'd1,
    PC_REG = 2'd2
  } pc_sel_t;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_MOV  = 5'd3;
  localparam logic [4:0] OP_LDW  = 5'd4;
  localparam logic [4:0] OP_STW  = 5'd5;
  localparam logic [4:0] OP_BR   = 5'd6;
  localparam logic [4:0] OP_JMP  = 5'd7;
  localparam logic [4:0] OP_JSRR = 5'd8;
  localparam logic [4:0] OP_JSR  = 5'd9;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

  function automatic logic writes_reg(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_MOV) || (op == OP_LDW);
  endfunction

  function automatic logic writes_link(input logic [4:0] op);
    return (op == OP_JSR) || (op == OP_JSRR);
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition: taken when any condition-code bit selected by the mask is set.
module branch_eval
  import ctrl_pkg::*;
(
  input  logic [2:0] nzp,
  input  logic [2:0] cc,
  output logic       taken
);

  assign taken = |(nzp & cc);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory-timeout abort, run-enable freeze and retired-instruction counting.
module stage_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lock,
  input  logic [4:0]  opcode,
  input  logic [2:0]  nzp,
  input  logic [2:0]  cc,
  input  logic        mem_ack,
  output logic        fetch_en,
  output logic        ir_ld,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        cc_we,
  output logic        link_we,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [4:0]         op_q;
  logic [2:0]         nzp_q;
  logic [31:0]        retired_q;
  logic               mem_err_q;
  logic               abort_q, abort_d;
  logic               err_set;
  logic               run;
  logic               taken;

  assign run = lock & ~reset;

  branch_eval u_branch_eval (
    .nzp   (nzp_q),
    .cc    (cc),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      op_q      <= '0;
      nzp_q     <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else if (lock) begin
      state_q <= state_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      if (err_set)
        mem_err_q <= 1'b1;
      if (state_q == DECODE) begin
        op_q  <= opcode;
        nzp_q <= nzp;
      end
      if (state_q == WRITEBACK)
        retired_q <= retired_q + 32'd1;
    end
  end

  // abort_q marks a timed-out access so only that instruction skips its register write
  always_comb begin
    state_d = FETCH;
    wait_d  = wait_q;
    abort_d = abort_q;
    err_set = 1'b0;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
        wait_d  = '0;
        abort_d = 1'b0;
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = is_mem_op(op_q) ? MEMORY : WRITEBACK;
      MEMORY: begin
        state_d = MEMORY;
        if (mem_ack) begin
          state_d = WRITEBACK;
          wait_d  = '0;
        end else if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = WRITEBACK;
          wait_d  = '0;
          abort_d = 1'b1;
          err_set = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WRITEBACK: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    fetch_en  = 1'b0;
    ir_ld     = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    cc_we     = 1'b0;
    link_we   = 1'b0;
    pc_ld     = 1'b0;
    pc_sel    = PC_SEQ;
    if (run) begin
      case (state_q)
        FETCH: begin
          fetch_en = 1'b1;
          ir_ld    = 1'b1;
        end
        DECODE:  decode_en = 1'b1;
        EXECUTE: exec_en   = 1'b1;
        MEMORY: begin
          mem_req = 1'b1;
          mem_we  = (op_q == OP_STW);
        end
        WRITEBACK: begin
          pc_ld   = 1'b1;
          reg_we  = writes_reg(op_q) & ~abort_q;
          cc_we   = writes_reg(op_q) & ~abort_q;
          link_we = writes_link(op_q);
          if ((op_q == OP_JSR) || ((op_q == OP_BR) && taken))
            pc_sel = PC_REL;
          else if ((op_q == OP_JMP) || (op_q == OP_JSRR))
            pc_sel = PC_REG;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomised bench for stage_sequencer: a per-instruction phase model predicts every
// output each cycle; directed scenarios pin the model with hand-computed values.
module tb_stage_sequencer;
  import ctrl_pkg::*;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lock = 1'b0;
  logic [4:0]  opcode = '0;
  logic [2:0]  nzp = '0;
  logic [2:0]  cc = '0;
  logic        mem_ack = 1'b0;
  logic        fetch_en, ir_ld, decode_en, exec_en, mem_req, mem_we;
  logic        reg_we, cc_we, link_we, pc_ld;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        mem_err;

  stage_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .lock(lock), .opcode(opcode), .nzp(nzp), .cc(cc),
    .mem_ack(mem_ack), .fetch_en(fetch_en), .ir_ld(ir_ld), .decode_en(decode_en),
    .exec_en(exec_en), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
    .cc_we(cc_we), .link_we(link_we), .pc_ld(pc_ld), .pc_sel(pc_sel),
    .state(state), .retired(retired), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        chk_rst_only = 1'b0;
  logic [9:0]  exp_strb = '0;
  logic [1:0]  exp_pc = '0;
  logic [2:0]  exp_state = '0;
  logic [31:0] exp_ret = '0;
  logic        exp_err = 1'b0;
  // Model architectural state
  logic [31:0] ret_cnt = '0;
  logic        err_sticky = 1'b0;

  wire [9:0] strb = {fetch_en, ir_ld, decode_en, exec_en, mem_req, mem_we,
                     reg_we, cc_we, link_we, pc_ld};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("strobes", 32'(strb), 32'(exp_strb));
      check("pc_sel", 32'(pc_sel), 32'(exp_pc));
      if (!chk_rst_only) begin
        check("state", 32'(state), 32'(exp_state));
        check("retired", retired, exp_ret);
        check("mem_err", 32'(mem_err), 32'(exp_err));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; lock = 1'($urandom); mem_ack = 1'($urandom); cc = 3'($urandom);
    chk_en = 1'b1; chk_rst_only = 1'b1; exp_strb = '0; exp_pc = '0;
    @(posedge clk); #1;
    lock = 1'($urandom); mem_ack = 1'($urandom);
    chk_rst_only = 1'b0; ret_cnt = '0; err_sticky = 1'b0;
    exp_state = 3'd0; exp_ret = '0; exp_err = 1'b0;
  endtask

  task automatic preset_retired(input logic [31:0] v);
    @(posedge clk); #1;
    reset = 1'b0; lock = 1'b0; mem_ack = 1'($urandom);
    exp_state = 3'd0; exp_strb = '0; exp_pc = '0; exp_err = err_sticky;
    force dut.retired_q = v;
    #1;
    release dut.retired_q;
    ret_cnt = v; exp_ret = v;
  endtask

  // Walks one instruction through its phases (0 F,1 D,2 E,3 M,4 W); lock=0 cycles hold the phase.
  task automatic run_instr(input logic [4:0] op, input logic [2:0] nz, input int ack_at,
                           input int lock_pct, input int cc_wb, input int mem_lock,
                           input int rst_ph, output int cycles, output int mreq,
                           output logic [1:0] wb_pc);
    int   ph = 0;
    int   k = 0;
    int   held = 0;
    logic abort = 1'b0;
    logic is_mem = (op == OP_LDW) || (op == OP_STW);
    logic wr = (op == OP_ADD) || (op == OP_AND) || (op == OP_MOV) || (op == OP_LDW);
    logic lk = (op == OP_JSR) || (op == OP_JSRR);
    cycles = 0; mreq = 0; wb_pc = 2'd0;
    while (ph <= 4) begin
      @(posedge clk); #1;
      cycles++;
      reset = 1'b0;
      lock = ($urandom_range(0, 99) >= lock_pct);
      opcode = 5'($urandom); nzp = 3'($urandom); cc = 3'($urandom); mem_ack = 1'($urandom);
      exp_state = 3'(ph); exp_ret = ret_cnt; exp_err = err_sticky; exp_strb = '0; exp_pc = '0;
      chk_en = 1'b1;
      if (ph == 1) begin opcode = op; nzp = nz; end
      if (ph == 3 && k == 1 && held < mem_lock) begin lock = 1'b0; mem_ack = 1'b1; held++; end
      if (lock) begin
        if (ph == rst_ph) begin
          reset = 1'b1;
          ph = 5;
        end else begin
          case (ph)
            0: begin exp_strb[9] = 1'b1; exp_strb[8] = 1'b1; ph = 1; end
            1: begin exp_strb[7] = 1'b1; ph = 2; end
            2: begin exp_strb[6] = 1'b1; ph = is_mem ? 3 : 4; end
            3: begin
              k++; mreq++;
              exp_strb[5] = 1'b1;
              exp_strb[4] = (op == OP_STW);
              mem_ack = (k == ack_at);
              if (k == ack_at) ph = 4;
              else if (k == T) begin abort = 1'b1; err_sticky = 1'b1; ph = 4; end
            end
            default: begin
              if (cc_wb >= 0) cc = 3'(cc_wb);
              exp_strb[3] = wr && !abort;
              exp_strb[2] = wr && !abort;
              exp_strb[1] = lk;
              exp_strb[0] = 1'b1;
              if (op == OP_BR)                          exp_pc = ((nz & cc) != 3'b000) ? 2'd1 : 2'd0;
              else if (op == OP_JSR)                    exp_pc = 2'd1;
              else if (op == OP_JMP || op == OP_JSRR)   exp_pc = 2'd2;
              wb_pc = exp_pc;
              ret_cnt = ret_cnt + 32'd1;
              ph = 5;
            end
          endcase
        end
      end
    end
  endtask

  logic [4:0] op_tab [11] = '{OP_ADD, OP_AND, OP_MOV, OP_LDW, OP_STW, OP_BR,
                              OP_JMP, OP_JSRR, OP_JSR, 5'd0, 5'd31};

  initial begin
    int         cyc, mr;
    logic [1:0] pcs;
    do_reset();

    run_instr(OP_ADD, 3'b000, 0, 0, -1, 0, -1, cyc, mr, pcs);
    check("add_cycles", 32'(cyc), 32'd4);
    check("add_pc_sel", 32'(pcs), 32'd0);
    check("add_retired", ret_cnt, 32'd1);

    run_instr(OP_LDW, 3'b000, 3, 0, -1, 0, -1, cyc, mr, pcs);
    check("ldw_cycles", 32'(cyc), 32'd7);
    check("ldw_mem_req_cycles", 32'(mr), 32'd3);

    run_instr(OP_BR, 3'b010, 0, 0, 2, 0, -1, cyc, mr, pcs);
    check("br_z_taken", 32'(pcs), 32'd1);
    run_instr(OP_BR, 3'b010, 0, 0, 1, 0, -1, cyc, mr, pcs);
    check("br_z_not_taken", 32'(pcs), 32'd0);
    run_instr(OP_BR, 3'b000, 0, 0, 4, 0, -1, cyc, mr, pcs);
    check("br_nomask", 32'(pcs), 32'd0);

    run_instr(OP_STW, 3'b000, 0, 0, -1, 0, -1, cyc, mr, pcs);
    check("stw_timeout_mem_cycles", 32'(mr), 32'd15);
    check("stw_timeout_cycles", 32'(cyc), 32'd19);
    check("stw_timeout_err", 32'(err_sticky), 32'd1);
    check("stw_pc_sel", 32'(pcs), 32'd0);

    run_instr(OP_LDW, 3'b000, 2, 0, -1, 3, -1, cyc, mr, pcs);
    check("lock_window_cycles", 32'(cyc), 32'd9);
    check("lock_window_mem_req", 32'(mr), 32'd2);

    do_reset();
    for (int i = 0; i < 150; i++) begin
      run_instr(op_tab[$urandom_range(0, 10)], 3'($urandom), $urandom_range(1, 18),
                15, -1, 0, -1, cyc, mr, pcs);
    end

    preset_retired(32'hFFFF_FFF0);
    run_instr(OP_JSR, 3'b000, 0, 0, -1, 0, 2, cyc, mr, pcs);
    do_reset();

    run_instr(OP_MOV, 3'b000, 0, 0, -1, 0, -1, cyc, mr, pcs);
    preset_retired(32'hFFFF_FFFF);
    run_instr(OP_ADD, 3'b000, 0, 0, -1, 0, -1, cyc, mr, pcs);
    check("retired_wrap_model", ret_cnt, 32'd0);

    @(posedge clk); #1;
    lock = 1'b0; exp_state = 3'd0; exp_strb = '0; exp_pc = '0; exp_ret = ret_cnt; exp_err = err_sticky;
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, sets the maximum MEMORY-state wait in cycles before abort.
REQ-002 Port clk  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port lock  input  1  run enable; 0 SHALL freeze the sequencer.
REQ-005 Port opcode  input  5  IR[31:27]; valid from DECODE onward.
REQ-006 Port nzp  input  3  IR[26:24] branch mask.
REQ-007 Port cc  input  3  datapath condition code (4=n, 2=z, 1=p).
REQ-008 Port mem_ack  input  1  data memory completion.
REQ-009 Outputs fetch_en, ir_ld, decode_en, exec_en, mem_req, mem_we, reg_we, cc_we, link_we, pc_ld SHALL each be 1-bit stage strobes.
REQ-010 Port pc_sel  output  2  next-PC source: 0=PC+4, 1=PC+4+(imm<<2), 2=src1 register.
REQ-011 Port state  output  3  current state encoding.
REQ-012 Port retired  output  32  retired-instruction count.
REQ-013 Port mem_err  output  1  sticky memory-timeout flag.

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4; codes 5-7 SHALL return to FETCH on the next edge.
REQ-015 FETCH SHALL assert fetch_en and ir_ld for one cycle, then go to DECODE.
REQ-016 DECODE SHALL assert decode_en, latch opcode and nzp into internal registers, then go to EXECUTE.
REQ-017 EXECUTE SHALL assert exec_en, then go to MEMORY for LDW/STW and to WRITEBACK otherwise.
REQ-018 MEMORY SHALL hold mem_req=1 (mem_we=1 only for STW) until mem_ack is sampled 1, then go to WRITEBACK; mem_req SHALL deassert the cycle after ack.
REQ-019 A wait counter SHALL count MEMORY cycles; on reaching MEM_TIMEOUT without ack, the sequencer SHALL set mem_err, skip reg_we/cc_we in WRITEBACK, and go to WRITEBACK.
REQ-020 WRITEBACK SHALL assert pc_ld for exactly one cycle, increment retired by 1 (wrapping at 2^32-1 to 0), then go to FETCH.
REQ-021 In WRITEBACK, reg_we and cc_we SHALL be 1 for ADD, AND, MOV, and LDW only.
REQ-022 In WRITEBACK, link_we SHALL be 1 for JSR and JSRR only.
REQ-023 pc_sel SHALL be 1 for JSR and for taken BR, 2 for JMP/JSRR, and 0 otherwise, including STW and unknown opcodes (NOP).
REQ-024 BR SHALL be taken iff (nzp_latched & cc) != 0, with cc sampled in WRITEBACK; nzp=000 SHALL never be taken.
REQ-025 All strobes SHALL be Moore decodes of the state and latched opcode, with no combinational path from mem_ack or cc to any strobe except pc_sel.
REQ-026 lock=0 SHALL hold the state, wait counter, and retired; it SHALL force every strobe, including mem_req, to 0 and ignore mem_ack.
REQ-027 When lock returns to 1 in MEMORY, mem_req SHALL reassert and the wait counter SHALL resume from its held value.
REQ-028 An instruction SHALL take 4 cycles, or 5+N cycles for LDW/STW where N is the ack wait, when lock=1 throughout.

Reset
REQ-029 While reset=1 at a clock edge: state=FETCH, wait counter=0, retired=0, mem_err=0, latched opcode/nzp=0, and all strobes and pc_sel SHALL be 0 during the reset cycle.
REQ-030 Reset SHALL override lock and abort any state, including MEMORY mid-handshake; mem_req SHALL be 0 in the cycle after the reset edge.
REQ-031 The first fetch_en SHALL occur in the first cycle with reset=0 and lock=1.

Structure
REQ-032 A shared package ctrl_pkg SHALL hold the state encodings, pc_sel encodings, and opcode constants matching global_def.h (OP_ADD, OP_AND, OP_MOV, OP_LDW, OP_STW, OP_BR, OP_JMP, OP_JSRR, OP_JSR).
REQ-033 One combinational sub-module, branch_eval (inputs nzp and cc; output taken), SHALL be instantiated.

Verification
REQ-034 Scenario: ADD after reset, lock=1 -> state sequence 0,1,2,4,0; reg_we=cc_we=pc_ld=1 in cycle 4; pc_sel=0; retired=1.
REQ-035 Scenario: LDW with mem_ack on the 3rd MEMORY cycle -> mem_req high 3 cycles, mem_we=0, reg_we in WRITEBACK, 7 cycles total.
REQ-036 Scenario: BR with nzp=010, cc=2 -> pc_sel=1; same with cc=1 -> pc_sel=0; nzp=000, cc=4 -> pc_sel=0.
REQ-037 Scenario: STW with no ack, MEM_TIMEOUT=15 -> mem_err=1 after 15 MEMORY cycles, no reg_we, pc_sel=0, FETCH resumes.
REQ-038 Scenario: lock=0 for 3 cycles in MEMORY, with ack during the lock=0 window -> ack ignored, state=3 held, strobes 0; completes on a later ack.
REQ-039 Scenario: reset in EXECUTE of JSR, and retired preset near 2^32-1 -> no link_we, state=0, retired=0; separately, retired wraps from 0xFFFFFFFF to 0.
